// File: rtl/k2_ctrl_pkg.sv
// k2_ctrl_pkg
//   Shared types and sizes for the K2 run controller slice.
//   run_state_t : controller sequence IDLE -> LOAD -> IDLE -> RUN -> DONE
//   PROG_DEPTH  : number of program bytes (16)
//   PROG_AW     : program address width (4)
//   INST_W      : instruction width (8)
package k2_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int PROG_DEPTH = 16;
  localparam int PROG_AW    = 4;
  localparam int INST_W     = 8;

endpackage

// File: rtl/k2_prog_mem.sv
// k2_prog_mem
//   16x8 program store that stands in for the K2 fixed ROM.
//   clk, rst_n : clock and asynchronous active-low clear (all bytes -> 8'h00)
//   we         : write enable, samples waddr/wdata on the rising clock edge
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address (driven by the processor's fetch address)
//   rdata      : read data, combinational, zero latency
module k2_prog_mem
  import k2_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [PROG_AW-1:0] waddr,
  input  logic [INST_W-1:0]  wdata,
  input  logic [PROG_AW-1:0] raddr,
  output logic [INST_W-1:0]  rdata
);

  logic [INST_W-1:0] mem_q [PROG_DEPTH];
  logic [INST_W-1:0] mem_d [PROG_DEPTH];

  // Next memory image: unchanged except for the addressed byte on a write.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Storage; reset wipes the whole program so a fresh core sees NOPs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Fetches behave like the ROM they replace: pure combinational lookup.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/k2_run_controller.sv
// k2_run_controller
//   Loads a program into the K2 program memory, releases the core from reset
//   to run it, captures every change of the core's Ro output, and stops the
//   core after OUT_COUNT captures or MAX_CYCLES run cycles.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   load_start/valid/data/last      : program byte stream in
//   load_ready                      : a byte is accepted this cycle
//   start, abort                    : run control pulses
//   core_rst_n                      : registered active-low reset to the core
//   fetch_addr, fetch_inst          : instruction fetch port of the core
//   core_ro                         : core Ro output
//   result_valid, result_data       : captured Ro value and its one-cycle strobe
//   busy, done, timeout             : status
module k2_run_controller
  import k2_ctrl_pkg::*;
#(
  parameter int BITS       = 8,
  parameter int OUT_COUNT  = 10,
  parameter int MAX_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_start,
  input  logic               load_valid,
  input  logic [INST_W-1:0]  load_data,
  input  logic               load_last,
  output logic               load_ready,
  input  logic               start,
  input  logic               abort,
  output logic               core_rst_n,
  input  logic [PROG_AW-1:0] fetch_addr,
  output logic [INST_W-1:0]  fetch_inst,
  input  logic [BITS-1:0]    core_ro,
  output logic               result_valid,
  output logic [BITS-1:0]    result_data,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int               CYC_W     = $clog2(MAX_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
  localparam logic [7:0]       OUT_LIMIT = 8'(OUT_COUNT);

  run_state_t         state_q, state_d;
  logic [PROG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic               prog_loaded_q, prog_loaded_d;
  logic [7:0]         out_cnt_q, out_cnt_d;
  logic [CYC_W-1:0]   cyc_cnt_q, cyc_cnt_d;
  logic [BITS-1:0]    prev_ro_q, prev_ro_d;
  logic [BITS-1:0]    result_data_q, result_data_d;
  logic               result_valid_q, result_valid_d;
  logic               timeout_q, timeout_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               mem_we;

  k2_prog_mem u_prog_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (load_data),
    .raddr (fetch_addr),
    .rdata (fetch_inst)
  );

  // Sequencing, load pointer, run counters and Ro change capture.
  // load_start always beats start; abort always beats any completion.
  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    prog_loaded_d  = prog_loaded_q;
    out_cnt_d      = out_cnt_q;
    cyc_cnt_d      = cyc_cnt_q;
    prev_ro_d      = prev_ro_q;
    result_data_d  = result_data_q;
    result_valid_d = 1'b0;
    timeout_d      = timeout_q;
    mem_we         = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (load_start) begin
          state_d   = LOAD;
          wr_ptr_d  = '0;
          timeout_d = 1'b0;
        end else if (start && prog_loaded_q) begin
          state_d   = RUN;
          cyc_cnt_d = '0;
          out_cnt_d = '0;
          prev_ro_d = '0;
          timeout_d = 1'b0;
        end
      end

      LOAD: begin
        if (abort) begin
          state_d       = IDLE;
          prog_loaded_d = 1'b0;
        end else if (load_valid) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PROG_AW'(1);
          // Leaving LOAD after the last slot guarantees no 17th byte lands.
          if (load_last || (wr_ptr_q == PROG_AW'(PROG_DEPTH - 1))) begin
            state_d       = IDLE;
            prog_loaded_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CYC_W'(1);
          if (core_ro != prev_ro_q) begin
            prev_ro_d      = core_ro;
            result_data_d  = core_ro;
            result_valid_d = 1'b1;
            out_cnt_d      = out_cnt_q + 8'd1;
          end
          if (out_cnt_d == OUT_LIMIT) begin
            state_d   = DONE;
            timeout_d = 1'b0;
          end else if (cyc_cnt_d == CYC_LIMIT) begin
            state_d   = DONE;
            timeout_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // The core runs exactly while the controller sits in RUN.
    core_rst_n_d = (state_d == RUN);
  end

  // State and registered outputs; reset pulls the core back into reset at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      prog_loaded_q  <= 1'b0;
      out_cnt_q      <= '0;
      cyc_cnt_q      <= '0;
      prev_ro_q      <= '0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      core_rst_n_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      prog_loaded_q  <= prog_loaded_d;
      out_cnt_q      <= out_cnt_d;
      cyc_cnt_q      <= cyc_cnt_d;
      prev_ro_q      <= prev_ro_d;
      result_data_q  <= result_data_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      core_rst_n_q   <= core_rst_n_d;
    end
  end

  assign load_ready   = (state_q == LOAD);
  assign busy         = (state_q == LOAD) || (state_q == RUN);
  assign done         = (state_q == DONE);
  assign core_rst_n   = core_rst_n_q;
  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign timeout      = timeout_q;

endmodule

// File: doc/k2_run_controller.md
Name: k2_run_controller

Overview:
Owns the K2 processor's 16x8 program memory and run sequence.
- Accepts a program over a valid/ready byte stream.
- Holds the core in reset until started, then releases it.
- Serves instruction fetches and captures each new value on the core's Ro output.
- Stops the core after a set number of outputs, or after a cycle budget runs out.
- Sits between the system/testbench and one K2_processor instance, and replaces the fixed program ROM.

Parameters:
- BITS, 8, width of the core's Ro output and of result_data.
- OUT_COUNT, 10, number of distinct Ro changes captured before the run ends (1..255).
- MAX_CYCLES, 1000, run-cycle budget before timeout (>=1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- load_start, input, 1, one-cycle pulse: begin loading a program.
- load_valid, input, 1, load byte valid.
- load_data, input, 8, instruction byte.
- load_last, input, 1, marks the final byte of the program.
- load_ready, output, 1, controller accepts a byte this cycle.
- start, input, 1, one-cycle pulse: run the loaded program.
- abort, input, 1, stop the run immediately.
- core_rst_n, output, 1, registered active-low reset to the processor.
- fetch_addr, input, 4, program address from the processor.
- fetch_inst, output, 8, instruction to the processor.
- core_ro, input, BITS, processor Ro output.
- result_valid, output, 1, one-cycle pulse: new result captured.
- result_data, output, BITS, captured Ro value.
- busy, output, 1, high in LOAD or RUN.
- done, output, 1, high in DONE.
- timeout, output, 1, run ended on cycle budget; valid while done=1.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - core_rst_n=0, load_ready=0, result_valid=0, result_data=0, busy=0, done=0, timeout=0.
  - wr_ptr=0, prog_loaded=0, out_cnt=0, cyc_cnt=0, prev_ro=0.
  - All 16 memory bytes = 8'h00.
- fetch_inst = mem[fetch_addr], combinational in every state (ROM-equivalent, zero latency).
- State IDLE:
  - load_start -> LOAD with wr_ptr=0.
  - Else, start with prog_loaded=1 -> RUN.
  - start with prog_loaded=0 is ignored.
  - If load_start and start arrive in the same cycle, load_start wins.
- State LOAD:
  - load_ready=1.
  - On each load_valid&load_ready beat: mem[wr_ptr]<=load_data, then wr_ptr++.
  - If the beat has load_last=1, or wr_ptr==15, go to IDLE with prog_loaded=1. load_ready drops the next cycle, so a 17th byte is never accepted.
  - start is ignored in LOAD. abort -> IDLE with prog_loaded=0.
- Entering RUN:
  - cyc_cnt=0, out_cnt=0, prev_ro=0.
  - core_rst_n goes 1 on the first cycle in RUN (registered).
- State RUN, each cycle:
  - cyc_cnt++.
  - If core_ro!=prev_ro: prev_ro<=core_ro, result_data<=core_ro, result_valid=1 on the next cycle, out_cnt++.
  - If the increment makes out_cnt reach OUT_COUNT -> DONE, timeout=0.
  - Else if cyc_cnt reaches MAX_CYCLES -> DONE, timeout=1.
  - If both happen in the same cycle, the output-count completion wins (timeout=0).
  - abort -> IDLE, core_rst_n=0 next cycle, no done. abort has priority over both completion conditions.
- State DONE:
  - done=1, core_rst_n=0.
  - result_data holds the last captured value.
  - start -> RUN (rerun the same program). load_start -> LOAD. load_start wins if both arrive.
- busy = (state==LOAD || state==RUN).
- result_valid is high for exactly one cycle per capture. Repeated equal Ro values produce no pulse.
- Counter widths:
  - cyc_cnt: $clog2(MAX_CYCLES+1).
  - out_cnt: 8 bits.
  - Neither counter wraps; each is bounded by its terminal transition.
- Asynchronous reset in any state returns everything to reset values, including clearing memory. core_rst_n falls immediately.

Decomposition:
- Package k2_ctrl_pkg holds:
  - enum run_state_t {IDLE, LOAD, RUN, DONE}.
  - localparams PROG_DEPTH=16, PROG_AW=4, INST_W=8.
- Sub-module k2_prog_mem: 16x8 register array with synchronous write port (we, waddr, wdata), combinational read port (raddr, rdata) and async clear.
- FSM, counters and Ro change detection stay in k2_run_controller.

Test Plan:
1. Load: load_start, then bytes 8'h11,8'h22,8'h33 with load_last on 8'h33 -> fetch_addr 0,1,2 return 11,22,33; addr 3 returns 00; busy drops after the third beat; load_ready=0 in IDLE.
2. Overflow: stream 17 bytes with load_last never set -> exactly 16 accepted; load_ready=0 after beat 16; mem[15]=byte 16.
3. Normal run (OUT_COUNT=5): a stub core drives Ro sequence 0,1,1,2,3,5,8 -> result pulses carry 1,2,3,5,8 (no pulse for the repeated 1); DONE after 8; timeout=0; core_rst_n=0 in DONE.
4. Timeout (MAX_CYCLES=20): core_ro held at 0 -> DONE exactly 20 cycles after entering RUN; timeout=1; no result_valid pulses.
5. Simultaneous end: the OUT_COUNT-th change lands on the cycle cyc_cnt hits MAX_CYCLES -> timeout=0. Also: abort mid-RUN -> IDLE, core_rst_n=0 next cycle, done=0.
6. Control edges: start before any load is ignored (state stays IDLE). rst_n asserted mid-LOAD -> memory reads 00 and all outputs return to reset values, asynchronously.
